icache_sa: RTL and testbench

Parametrised set-associative instruction cache between the instruction-fetch stage and the memory controller. It supersedes the direct-mapped, one-word-per-line cache with:
- configurable ways, sets and line length;
- a multi-beat line-refill state machine;
- per-set FIFO replacement;
- a whole-cache invalidate sequence for fence.i.

Hits answer one cycle after the request; misses fetch the full line from memory, one word per beat.

---
 rtl/icache_sa_if.sv | 17 +
 rtl/icache_sa.sv | 181 ++++++++++++++++++
 tb/tb_icache_sa.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side handshake bundle for icache_sa.
// slave = cache side, master = fetch stage plus memory controller.
interface icache_sa_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_data;

  modport master (output if_req, if_addr, mem_valid, mem_data,
                  input  if_valid, if_inst, mem_req, mem_addr);
  modport slave  (input  if_req, if_addr, mem_valid, mem_data,
                  output if_valid, if_inst, mem_req, mem_addr);
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-beat refill, per-set FIFO
// replacement and a one-set-per-cycle invalidate sweep for fence.i.
//
// state    | meaning
// S_IDLE   | lookups accepted; hits answered next cycle
// S_REFILL | fetching a line one word per beat
// S_FLUSH  | clearing one set per cycle, index 0..SETS-1
module icache_sa #(
  parameter int ADDR_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  input  logic       clear,
  input  logic       flush,
  output logic       busy,
  icache_sa_if.slave bus
);
  localparam int OW = $clog2(LINE_WORDS) + 2;
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - IW - OW;
  localparam int WW = $clog2(LINE_WORDS);
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WW-1:0] LAST = WW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FLUSH} state_t;

  state_t            state;
  logic [WAYS-1:0]   valid_q [SETS];
  logic [VW-1:0]     vptr_q  [SETS];
  logic [TW-1:0]     tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS][LINE_WORDS];
  logic [31:0]       line_buf [LINE_WORDS];

  logic [WW-1:0]     beat;
  logic [TW-1:0]     m_tag;
  logic [IW-1:0]     m_idx;
  logic [WW-1:0]     m_wsel;
  logic [IW-1:0]     fidx;
  logic              cancel_q, flush_pend;
  logic              if_valid_q, mem_req_q;
  logic [31:0]       if_inst_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic [WW-1:0]     req_wsel;
  logic              hit, evict, accept, beat_ok, install;
  logic [31:0]       hit_word;
  logic [VW-1:0]     victim;
  logic              unused_addr_bits;

  assign req_idx  = bus.if_addr[OW+IW-1:OW];
  assign req_tag  = bus.if_addr[ADDR_W-1:OW+IW];
  assign req_wsel = bus.if_addr[OW-1:2];
  assign unused_addr_bits = ^bus.if_addr[1:0];

  assign accept  = (state == S_IDLE) && !flush && bus.if_req && !if_valid_q && !clear;
  assign beat_ok = rdy_in && (state == S_REFILL) && bus.mem_valid;
  assign install = beat_ok && (beat == LAST);

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit      = 1'b1;
        hit_word = data_q[w][req_idx][req_wsel];
      end
    end
  end

  // Lowest-index invalid way wins; only a full set falls back to the FIFO pointer.
  always_comb begin
    victim = vptr_q[m_idx];
    evict  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[m_idx][w]) begin
        victim = VW'(w);
        evict  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= S_IDLE;
      beat       <= '0;
      m_tag      <= '0;
      m_idx      <= '0;
      m_wsel     <= '0;
      fidx       <= '0;
      cancel_q   <= 1'b0;
      flush_pend <= 1'b0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
    end else if (rdy_in) begin
      if_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            state <= S_FLUSH;
            fidx  <= '0;
          end else if (accept) begin
            if (hit) begin
              if_valid_q <= 1'b1;
              if_inst_q  <= hit_word;
            end else begin
              state      <= S_REFILL;
              m_tag      <= req_tag;
              m_idx      <= req_idx;
              m_wsel     <= req_wsel;
              beat       <= '0;
              cancel_q   <= 1'b0;
              flush_pend <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {bus.if_addr[ADDR_W-1:OW], {OW{1'b0}}};
            end
          end
        end
        S_REFILL: begin
          if (clear) cancel_q <= 1'b1;
          if (flush) flush_pend <= 1'b1;
          if (bus.mem_valid) begin
            if (beat == m_wsel) if_inst_q <= bus.mem_data;
            if (beat == LAST) begin
              valid_q[m_idx][victim] <= 1'b1;
              if (evict && (WAYS > 1)) vptr_q[m_idx] <= vptr_q[m_idx] + VW'(1);
              mem_req_q  <= 1'b0;
              beat       <= '0;
              if_valid_q <= !(cancel_q || clear);
              if (flush_pend || flush) begin
                state <= S_FLUSH;
                fidx  <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              beat       <= beat + WW'(1);
              mem_addr_q <= mem_addr_q + ADDR_W'(4);
            end
          end
        end
        S_FLUSH: begin
          valid_q[fidx] <= '0;
          vptr_q[fidx]  <= '0;
          fidx          <= fidx + IW'(1);
          if (fidx == IW'(SETS - 1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset: a valid bit always guards it.
  always_ff @(posedge clk_in) begin
    if (beat_ok) begin
      line_buf[beat] <= bus.mem_data;
      if (install) begin
        tag_q[victim][m_idx] <= m_tag;
        for (int w = 0; w < LINE_WORDS; w++)
          data_q[victim][m_idx][w] <= (WW'(w) == LAST) ? bus.mem_data : line_buf[w];
      end
    end
  end

  assign busy         = (state != S_IDLE);
  assign bus.if_valid = if_valid_q;
  assign bus.if_inst  = if_inst_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa; memory returns {addr[15:0], ~addr[15:0]} for each beat.
module tb_icache_sa;
  logic clk_in = 1'b0;
  logic rst_n_in, rdy_in, clear, flush, busy;
  logic mem_auto, mem_man;
  int   checks = 0;
  int   errors = 0;

  icache_sa_if #(.ADDR_W(32)) bus ();

  icache_sa #(.ADDR_W(32), .WAYS(2), .SETS(64), .LINE_WORDS(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .clear(clear), .flush(flush), .busy(busy), .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  assign bus.mem_valid = mem_auto ? bus.mem_req : mem_man;
  assign bus.mem_data  = {bus.mem_addr[15:0], ~bus.mem_addr[15:0]};

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; flush = 1'b0;
    mem_auto = 1'b1; mem_man = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    step(); step();
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] inst,
                       output int lat, output bit saw_mreq);
    bus.if_req = 1'b1; bus.if_addr = a;
    lat = 0; saw_mreq = 1'b0; inst = '0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.mem_req) saw_mreq = 1'b1;
      if (bus.if_valid) begin
        lat  = i;
        inst = bus.if_inst;
        break;
      end
    end
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got %b exp 0", bus.if_valid); end
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", bus.mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (bus.if_inst !== 32'h0) begin errors++; $display("FAIL reset_if_inst got %h exp 0", bus.if_inst); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr); end
  endtask

  task automatic test_cold_miss();
    logic [31:0] inst; int lat; bit mr;
    do_reset();
    mem_auto = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1004;
    step();
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL cold_mem_req got %b exp 1", bus.mem_req); end
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        mem_man = 1'b0;
        step();
        checks++; if (bus.mem_addr !== 32'h1008) begin errors++; $display("FAIL cold_addr_hold got %h exp 1008", bus.mem_addr); end
      end
      checks++; if (bus.mem_addr !== 32'h1000 + 32'(4 * b)) begin errors++; $display("FAIL cold_beat_addr%0d got %h exp %h", b, bus.mem_addr, 32'h1000 + 32'(4 * b)); end
      mem_man = 1'b1;
      step();
    end
    mem_man = 1'b0;
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL cold_if_valid got %b exp 1", bus.if_valid); end
    checks++; if (bus.if_inst !== 32'h1004_EFFB) begin errors++; $display("FAIL cold_if_inst got %h exp 1004effb", bus.if_inst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cold_busy got %b exp 0", busy); end
    bus.if_req = 1'b0;
    step();
    mem_auto = 1'b1;
    fetch(32'h0000_100C, inst, lat, mr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL cold_refetch_lat got %0d exp 1", lat); end
    checks++; if (mr !== 1'b0) begin errors++; $display("FAIL cold_refetch_memreq got %b exp 0", mr); end
    checks++; if (inst !== 32'h100C_EFF3) begin errors++; $display("FAIL cold_refetch_inst got %h exp 100ceff3", inst); end
  endtask

  task automatic test_replacement();
    logic [31:0] inst; int lat; bit mr;
    do_reset();
    fetch(32'h0000_0000, inst, lat, mr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL repl_fill0_lat got %0d exp 5", lat); end
    checks++; if (inst !== 32'h0000_FFFF) begin errors++; $display("FAIL repl_fill0_inst got %h exp 0000ffff", inst); end
    fetch(32'h0000_0400, inst, lat, mr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL repl_fill1_lat got %0d exp 5", lat); end
    fetch(32'h0000_0800, inst, lat, mr);
    checks++; if (inst !== 32'h0800_F7FF) begin errors++; $display("FAIL repl_fill2_inst got %h exp 0800f7ff", inst); end
    fetch(32'h0000_0400, inst, lat, mr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL repl_hit400_lat got %0d exp 1", lat); end
    checks++; if (inst !== 32'h0400_FBFF) begin errors++; $display("FAIL repl_hit400_inst got %h exp 0400fbff", inst); end
    fetch(32'h0000_0000, inst, lat, mr);
    checks++; if (mr !== 1'b1 || lat !== 5) begin errors++; $display("FAIL repl_miss000 got memreq %b lat %0d exp 1 5", mr, lat); end
    fetch(32'h0000_0800, inst, lat, mr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL repl_hit800_lat got %0d exp 1", lat); end
    fetch(32'h0000_0400, inst, lat, mr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL repl_fifo400_lat got %0d exp 5", lat); end
  endtask

  task automatic test_clear_refill();
    logic [31:0] inst; int lat; bit mr;
    do_reset();
    mem_auto = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_2008;
    step();
    mem_man = 1'b1;
    step(); step();
    clear = 1'b1;
    step();
    clear = 1'b0; bus.if_req = 1'b0;
    step();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL clear_if_valid got %b exp 0", bus.if_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b exp 0", busy); end
    mem_man = 1'b0;
    step();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL clear_if_valid_late got %b exp 0", bus.if_valid); end
    mem_auto = 1'b1;
    fetch(32'h0000_2008, inst, lat, mr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL clear_refetch_lat got %0d exp 1", lat); end
    checks++; if (inst !== 32'h2008_DFF7) begin errors++; $display("FAIL clear_refetch_inst got %h exp 2008dff7", inst); end
  endtask

  task automatic test_flush_refill();
    logic [31:0] inst; int lat; bit mr; int n;
    do_reset();
    fetch(32'h0000_3000, inst, lat, mr);
    mem_auto = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_3010;
    step();
    mem_man = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    step(); step(); step();
    mem_man = 1'b0; bus.if_req = 1'b0;
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL flref_if_valid got %b exp 1", bus.if_valid); end
    checks++; if (bus.if_inst !== 32'h3010_CFEF) begin errors++; $display("FAIL flref_if_inst got %h exp 3010cfef", bus.if_inst); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flref_busy got %b exp 1", busy); end
    n = 0;
    while (busy && n < 200) begin n++; step(); end
    checks++; if (n !== 64) begin errors++; $display("FAIL flref_busy_cycles got %0d exp 64", n); end
    mem_auto = 1'b1;
    fetch(32'h0000_3000, inst, lat, mr);
    checks++; if (mr !== 1'b1 || lat !== 5) begin errors++; $display("FAIL flref_miss3000 got memreq %b lat %0d exp 1 5", mr, lat); end
    fetch(32'h0000_3010, inst, lat, mr);
    checks++; if (mr !== 1'b1 || lat !== 5) begin errors++; $display("FAIL flref_miss3010 got memreq %b lat %0d exp 1 5", mr, lat); end
  endtask

  task automatic test_flush_idle();
    logic [31:0] inst; int lat; bit mr; int n;
    do_reset();
    fetch(32'h0000_4000, inst, lat, mr);
    flush = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h0000_4000;
    step();
    flush = 1'b0; bus.if_req = 1'b0;
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL flidle_priority got %b exp 0", bus.if_valid); end
    n = 0;
    while (busy && n < 200) begin flush = (n == 10); n++; step(); end
    flush = 1'b0;
    checks++; if (n !== 64) begin errors++; $display("FAIL flidle_busy_cycles got %0d exp 64", n); end
    fetch(32'h0000_4000, inst, lat, mr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL flidle_miss_lat got %0d exp 5", lat); end
  endtask

  task automatic test_rdy_stall();
    logic [31:0] inst; int lat; bit mr;
    do_reset();
    mem_auto = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_5004;
    step();
    mem_man = 1'b1;
    step();
    checks++; if (bus.mem_addr !== 32'h5004) begin errors++; $display("FAIL rdy_addr_beat1 got %h exp 5004", bus.mem_addr); end
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.mem_addr !== 32'h5004 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL rdy_hold%0d got addr %h req %b exp 5004 1", i, bus.mem_addr, bus.mem_req); end
    end
    rdy_in = 1'b1;
    step();
    checks++; if (bus.mem_addr !== 32'h5008) begin errors++; $display("FAIL rdy_resume_addr got %h exp 5008", bus.mem_addr); end
    step(); step();
    mem_man = 1'b0;
    checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h5004_AFFB) begin errors++; $display("FAIL rdy_resp got valid %b inst %h exp 1 5004affb", bus.if_valid, bus.if_inst); end
    bus.if_req = 1'b0;
    step();
    mem_auto = 1'b1;
    fetch(32'h0000_500C, inst, lat, mr);
    checks++; if (lat !== 1 || inst !== 32'h500C_AFF3) begin errors++; $display("FAIL rdy_line_hit got lat %0d inst %h exp 1 500caff3", lat, inst); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] inst; int lat; bit mr;
    do_reset();
    mem_auto = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_6000;
    step();
    mem_man = 1'b1;
    step();
    #2 rst_n_in = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req got %b exp 0", bus.mem_req); end
    checks++; if (bus.if_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_valid_busy got %b %b exp 0 0", bus.if_valid, busy); end
    mem_man = 1'b0; bus.if_req = 1'b0;
    step();
    rst_n_in = 1'b1;
    step();
    mem_auto = 1'b1;
    fetch(32'h0000_6000, inst, lat, mr);
    checks++; if (mr !== 1'b1 || lat !== 5) begin errors++; $display("FAIL rstmid_miss got memreq %b lat %0d exp 1 5", mr, lat); end
    checks++; if (inst !== 32'h6000_9FFF) begin errors++; $display("FAIL rstmid_inst got %h exp 60009fff", inst); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst; int lat; bit mr;
    do_reset();
    fetch(32'h0000_7000, inst, lat, mr);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_7000;
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h7000_8FFF) begin errors++; $display("FAIL b2b_first got %b %h exp 1 70008fff", bus.if_valid, bus.if_inst); end
    bus.if_addr = 32'h0000_7004;
    step();
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", bus.if_valid); end
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h7004_8FFB) begin errors++; $display("FAIL b2b_second got %b %h exp 1 70048ffb", bus.if_valid, bus.if_inst); end
    bus.if_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_replacement();
    test_clear_refill();
    test_flush_refill();
    test_flush_idle();
    test_rdy_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
